sseg_scan_ctrl: RTL and testbench
=================================

# sseg_scan_ctrl

Parametrised N-digit multiplexed seven-segment scan controller, the successor to the fixed 4-digit display mux. It time-multiplexes DIGITS active-low digit patterns onto one shared segment bus. Per-slot dead time suppresses ghosting, per-digit enables blank individual digits, and an optional PWM stage dims the display. Frame data is double-buffered behind a load strobe and takes effect only at frame boundaries, so the display never tears. It sits between the number-formatting logic (hex/BCD-to-7seg encoders) and the board's anode/segment pins.

## Interface
- DIGITS, 8, number of digits scanned (2..16)
- PRESC_W, 16, slot-counter width; each digit slot lasts 2^PRESC_W clk cycles
- BRIGHT_W, 4, brightness code width (requires PRESC_W >= BRIGHT_W+1)
- DEAD, 4, blank cycles at the start of each slot (requires DEAD < 2^(PRESC_W-BRIGHT_W))
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- seg_in  in  7*DIGITS  active-low segment patterns a..g; digit k occupies bits [7k+6:7k]
- dp_in  in  DIGITS  decimal point per digit, active-high
- digit_en  in  DIGITS  per-digit enable, 1 = shown
- bright  in  BRIGHT_W  brightness code, sampled live (not buffered)
- load  in  1  single-cycle strobe that captures seg_in/dp_in/digit_en into the pending buffer
- upd_pending  out  1  pending buffer holds data not yet applied
- an  out  DIGITS  active-low anodes, at most one low
- sseg  out  8  active-low segments; bit 7 = dp, bits 6:0 = g..a
- digit_idx  out  $clog2(DIGITS)  digit currently in its slot
- frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot

## Operation
- Slot counter p counts 0..2^PRESC_W-1, free-running. On wrap, digit_idx increments; DIGITS-1 wraps to 0, which is a frame boundary.
- Lit condition for the current digit: p >= DEAD, active digit_en[idx]=1, and (under dimming) p[PRESC_W-1 -: BRIGHT_W] <= bright.
- When lit: an[idx]=0 and all other anodes =1; sseg[6:0] = active pattern[idx]; sseg[7] = ~active dp[idx].
- When not lit: an = all 1s and sseg = 8'hFF.
- Buffers: load=1 writes seg_in/dp_in/digit_en into pending and sets upd_pending.
- At a frame boundary with upd_pending=1, pending is copied to active and upd_pending clears.
- Simultaneous load and frame boundary: the pending contents held before that cycle are applied, the new load is captured into pending, and upd_pending stays 1. That data applies at the next frame.
- Repeated loads within one frame: the last one wins.
- Reset values: p=0, digit_idx=0, an all 1s, sseg=8'hFF, frame_start=0, upd_pending=0, pending and active patterns all 1s (blank), dp=0, digit_en=0. The display stays dark until the first load has been applied.
- Reset mid-frame: all state returns immediately to the reset values, and pending data is discarded.

## Timing
- an, sseg and frame_start are registered. They reflect the counter state of the previous cycle, so latency from p/idx to the pins is 1 clk.
- digit_idx and upd_pending are register outputs with no extra delay.
- frame_start is high for the one cycle in which the pins show p=0, idx=0.
- A load applies no earlier than the next frame boundary and no later than the second one.
- Frame period is DIGITS*2^PRESC_W cycles.
- bright changes take effect on the next cycle's lit evaluation.

## Configuration
- SSEG_SCAN_DIM_EN defined: PWM term active as described. bright=all 1s gives a lit time of 2^PRESC_W-DEAD per slot; bright=0 gives 2^(PRESC_W-BRIGHT_W)-DEAD.
- SSEG_SCAN_DIM_EN undefined: PWM term removed, bright is ignored, and each enabled digit is lit for p >= DEAD.

## Test plan
Run with DIGITS=4, PRESC_W=4, BRIGHT_W=2, DEAD=2 (16-cycle slot, 64-cycle frame).
- Reset, then no load for 200 cycles -> an=4'hF and sseg=8'hFF throughout; frame_start pulses every 64 cycles; upd_pending=0.
- Load seg_in={7'h40,7'h79,7'h24,7'h30}, dp_in=4'b0010, digit_en=4'hF, bright=3 -> upd_pending=1 until the next frame boundary. Then each slot shows 2 blank cycles followed by 14 lit cycles: idx1 gives an=4'b1101 and sseg=8'h24; idx0 gives an=4'b1110 and sseg=8'hB0.
- With DIM_EN and bright=0 -> 2 lit cycles per slot (p=2,3), blank for p=4..15. Without DIM_EN -> 14 lit cycles regardless of bright.
- digit_en=4'b1011 -> slot 2 is fully blank (an=4'hF); the other slots are unchanged.
- Assert load in the exact cycle of a frame boundary while earlier pending data exists -> the earlier data is shown that frame, the new data the following frame, and upd_pending stays 1 across the boundary.
- Assert reset mid-slot at idx=2 with upd_pending=1 -> next cycle an=4'hF, sseg=8'hFF, digit_idx=0, upd_pending=0; the display stays blank after reset release.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller with dead time, per-digit
// enables and frame-synchronous double buffering. Define SSEG_SCAN_DIM_EN for PWM dimming.
module sseg_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int PRESC_W  = 16,
    parameter int BRIGHT_W = 4,
    parameter int DEAD     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7*DIGITS-1:0]        seg_in,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic [DIGITS-1:0]          digit_en,
    input  logic [BRIGHT_W-1:0]        bright,
    input  logic                       load,
    output logic                       upd_pending,
    output logic [DIGITS-1:0]          an,
    output logic [7:0]                 sseg,
    output logic [$clog2(DIGITS)-1:0]  digit_idx,
    output logic                       frame_start
);
    localparam int IDX_W = $clog2(DIGITS);

    logic [PRESC_W-1:0]  p_reg, p_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [7*DIGITS-1:0] pend_seg_reg, act_seg_reg;
    logic [DIGITS-1:0]   pend_dp_reg, act_dp_reg;
    logic [DIGITS-1:0]   pend_en_reg, act_en_reg;
    logic                upd_reg;
    logic [DIGITS-1:0]   an_reg, an_next;
    logic [7:0]          sseg_reg, sseg_next;
    logic                fs_reg, fs_next;

    logic                slot_wrap, frame_wrap, lit;
    logic [6:0]          act_pat [DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign act_pat[gi] = act_seg_reg[7*gi +: 7];
            assign an_next[gi] = ~(lit && (idx_reg == IDX_W'(gi)));
        end
    endgenerate

    always_comb begin
        slot_wrap  = (p_reg == '1);
        frame_wrap = slot_wrap && (idx_reg == IDX_W'(DIGITS-1));
        p_next     = p_reg + 1'b1;
        idx_next   = idx_reg;
        if (slot_wrap) begin
            idx_next = frame_wrap ? '0 : idx_reg + 1'b1;
        end
    end

    // Lit evaluation uses the current counter; the pins register it one cycle later.
    always_comb begin
        lit = (p_reg >= PRESC_W'(DEAD)) && act_en_reg[idx_reg];
`ifdef SSEG_SCAN_DIM_EN
        lit = lit && (p_reg[PRESC_W-1 -: BRIGHT_W] <= bright);
`endif
        sseg_next = lit ? {~act_dp_reg[idx_reg], act_pat[idx_reg]} : 8'hFF;
        fs_next   = (p_reg == '0) && (idx_reg == '0);
    end

`ifndef SSEG_SCAN_DIM_EN
    logic unused_bright;
    assign unused_bright = ^bright;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg    <= '0;
            idx_reg  <= '0;
            an_reg   <= '1;
            sseg_reg <= 8'hFF;
            fs_reg   <= 1'b0;
        end else begin
            p_reg    <= p_next;
            idx_reg  <= idx_next;
            an_reg   <= an_next;
            sseg_reg <= sseg_next;
            fs_reg   <= fs_next;
        end
    end

    // On a boundary coinciding with a load, the old pending data goes active
    // while the new load lands in pending and stays flagged for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_seg_reg <= '1;
            pend_dp_reg  <= '0;
            pend_en_reg  <= '0;
            act_seg_reg  <= '1;
            act_dp_reg   <= '0;
            act_en_reg   <= '0;
            upd_reg      <= 1'b0;
        end else begin
            if (frame_wrap && upd_reg) begin
                act_seg_reg <= pend_seg_reg;
                act_dp_reg  <= pend_dp_reg;
                act_en_reg  <= pend_en_reg;
            end
            if (load) begin
                pend_seg_reg <= seg_in;
                pend_dp_reg  <= dp_in;
                pend_en_reg  <= digit_en;
                upd_reg      <= 1'b1;
            end else if (frame_wrap) begin
                upd_reg <= 1'b0;
            end
        end
    end

    assign an          = an_reg;
    assign sseg        = sseg_reg;
    assign frame_start = fs_reg;
    assign digit_idx   = idx_reg;
    assign upd_pending = upd_reg;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized self-checking bench for sseg_scan_ctrl against a time-based model:
// slot and digit are derived from cycles elapsed since reset.
module tb_sseg_scan_ctrl;
    localparam int DIGITS   = 4;
    localparam int PRESC_W  = 4;
    localparam int BRIGHT_W = 2;
    localparam int DEAD     = 2;
    localparam int SLOT     = 1 << PRESC_W;
    localparam int FRAME    = DIGITS * SLOT;
    localparam int STEP_W   = SLOT >> BRIGHT_W;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [7*DIGITS-1:0] seg_in = '1;
    logic [DIGITS-1:0]   dp_in = '0;
    logic [DIGITS-1:0]   digit_en = '0;
    logic [BRIGHT_W-1:0] bright = '0;
    logic                load = 1'b0;
    logic                upd_pending;
    logic [DIGITS-1:0]   an;
    logic [7:0]          sseg;
    logic [1:0]          digit_idx;
    logic                frame_start;

    sseg_scan_ctrl #(.DIGITS(DIGITS), .PRESC_W(PRESC_W), .BRIGHT_W(BRIGHT_W), .DEAD(DEAD)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .dp_in(dp_in), .digit_en(digit_en),
        .bright(bright), .load(load), .upd_pending(upd_pending), .an(an), .sseg(sseg),
        .digit_idx(digit_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state: time since reset plus the two buffers.
    int         m_t;
    logic [6:0] m_pseg [DIGITS];
    logic [6:0] m_aseg [DIGITS];
    logic [DIGITS-1:0] m_pdp, m_adp, m_pen, m_aen;
    bit         m_upd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0;
        for (int k = 0; k < DIGITS; k++) begin
            m_pseg[k] = 7'h7F;
            m_aseg[k] = 7'h7F;
        end
        m_pdp = '0; m_adp = '0; m_pen = '0; m_aen = '0;
        m_upd = 0;
    endtask

    task automatic step();
        int p, idx;
        bit lit;
        logic [DIGITS-1:0] e_an;
        logic [7:0] e_sseg;
        bit e_fs;
        @(posedge clk);
        p   = m_t % SLOT;
        idx = (m_t / SLOT) % DIGITS;
        lit = (p >= DEAD) && m_aen[idx];
`ifdef SSEG_SCAN_DIM_EN
        lit = lit && ((p / STEP_W) <= int'(bright));
`endif
        e_an = '1;
        if (lit) e_an[idx] = 1'b0;
        e_sseg = lit ? {~m_adp[idx], m_aseg[idx]} : 8'hFF;
        e_fs = ((m_t % FRAME) == 0);
        if ((m_t % FRAME) == FRAME-1 && m_upd) begin
            for (int k = 0; k < DIGITS; k++) m_aseg[k] = m_pseg[k];
            m_adp = m_pdp;
            m_aen = m_pen;
            m_upd = 0;
        end
        if (load) begin
            for (int k = 0; k < DIGITS; k++) m_pseg[k] = seg_in[7*k +: 7];
            m_pdp = dp_in;
            m_pen = digit_en;
            m_upd = 1;
        end
        m_t++;
        #1;
        check_val("an", 32'(an), 32'(e_an));
        check_val("sseg", 32'(sseg), 32'(e_sseg));
        check_val("frame_start", 32'(frame_start), 32'(e_fs));
        check_val("digit_idx", 32'(digit_idx), 32'((m_t / SLOT) % DIGITS));
        check_val("upd_pending", 32'(upd_pending), 32'(m_upd));
    endtask

    task automatic run(input int n, input bit rand_bright);
        for (int i = 0; i < n; i++) begin
            if (rand_bright) bright = BRIGHT_W'($urandom);
            step();
        end
    endtask

    task automatic run_to(input int phase);
        while ((m_t % FRAME) != phase) step();
    endtask

    task automatic do_load(input logic [7*DIGITS-1:0] s, input logic [DIGITS-1:0] d,
                           input logic [DIGITS-1:0] e);
        seg_in = s; dp_in = d; digit_en = e; load = 1'b1;
        $display("load seg=%h dp=%b en=%b bright=%0d phase=%0d", s, d, e, bright, m_t % FRAME);
        step();
        load = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_an"}, 32'(an), 32'hF);
        check_val({tag, "_sseg"}, 32'(sseg), 32'hFF);
        check_val({tag, "_idx"}, 32'(digit_idx), 32'h0);
        check_val({tag, "_upd"}, 32'(upd_pending), 32'h0);
        check_val({tag, "_fs"}, 32'(frame_start), 32'h0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        @(negedge clk);
        reset = 1'b0;

        // Dark display with no load, frame_start every FRAME cycles
        run(200, 1'b1);

        // Reference pattern, full brightness, then minimum brightness
        bright = 2'd3;
        do_load({7'h40, 7'h79, 7'h24, 7'h30}, 4'b0010, 4'hF);
        run(2*FRAME, 1'b0);
        bright = 2'd0;
        run(FRAME, 1'b0);
        bright = 2'd3;

        // Digit 2 disabled
        do_load({7'h40, 7'h79, 7'h24, 7'h30}, 4'b0010, 4'b1011);
        run(2*FRAME, 1'b0);

        // Load on the exact boundary cycle while older data is pending
        run_to(20);
        do_load(28'($urandom), 4'($urandom), 4'($urandom));
        run_to(FRAME-1);
        do_load(28'($urandom), 4'($urandom), 4'($urandom));
        run(2*FRAME, 1'b0);

        // Random loads (sometimes several per frame) with live brightness changes
        for (int it = 0; it < 12; it++) begin
            run($urandom_range(0, 90), 1'b1);
            do_load(28'($urandom), 4'($urandom), 4'($urandom));
        end
        run(2*FRAME, 1'b1);

        // Reset mid-slot in digit 2 with data pending
        run_to(2*SLOT + 1);
        do_load(28'($urandom), 4'($urandom), 4'hF);
        run_to(2*SLOT + 7);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run(150, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
